calib_scheduler: RTL and testbench
==================================

Name: calib_scheduler

Overview:
- Shares one calibration pipeline (gain multiply, divide by 2^FRAC_BITS, trim toward zero, saturation) between the two waveform channels.
- Runs a round-robin arbiter over the two channels' valid/ready sample requests, then sequences each sample through the pipeline.
- Holds per-channel gain/trim configuration registers.
- Sits between the channel waveform generators and the DAC interface.

Parameters:
- W, 16, sample and coefficient width (signed)
- FRAC_BITS, 8, divisor exponent (divide by 256)
- GAIN_RST, 250, reset gain for both channels
- TRIM_RST, 3, reset trim magnitude for both channels

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  1  allow new sample acceptance
- ch0_valid  in  1  channel 0 sample request
- ch0_data  in  W  channel 0 signed sample
- ch0_ready  out  1  channel 0 accept (combinational)
- ch1_valid  in  1  channel 1 sample request
- ch1_data  in  W  channel 1 signed sample
- ch1_ready  out  1  channel 1 accept (combinational)
- cfg_we  in  1  config write strobe
- cfg_ch  in  1  config target channel
- cfg_gain  in  W  signed gain
- cfg_trim  in  W  unsigned trim magnitude
- out_valid  out  1  calibrated sample valid
- out_ready  in  1  downstream accept
- out_ch  out  1  channel tag of out_data
- out_data  out  W  calibrated signed sample
- sat_flag  out  2  sticky per-channel saturation flag

Behaviour:
- Single clock clk; reset rst is synchronous, active-high.
- Reset values:
  - state=IDLE; out_valid=0, out_ch=0, out_data=0, sat_flag=0.
  - Both gains=GAIN_RST, both trims=TRIM_RST.
  - last_grant=1, so channel 0 wins the first tie.
- A reset asserted mid-operation aborts the in-flight sample: it is discarded and no out_valid is produced.
- FSM states: IDLE -> MUL -> DIV -> TRIM -> OUT -> IDLE. Only one sample is in flight at a time.
- IDLE:
  - chX_ready = (state==IDLE) & en & grant_X.
  - If only one channel is valid, it is granted.
  - If both are valid, the channel other than last_grant is granted.
  - At the accepting edge: latch data, channel, and that channel's current gain and trim (snapshot); update last_grant; go to MUL.
  - With en=0 nothing is accepted; any in-flight sample still completes.
- MUL: prod (2W signed) <= data*gain.
- DIV:
  - q <= prod / 2^FRAC_BITS, truncating toward zero (not an arithmetic shift; -1/256 = 0).
  - Saturate q to [-2^(W-1), 2^(W-1)-1].
  - On saturation, set sat_flag[ch].
- TRIM:
  - If |q| <= trim, result is 0.
  - Otherwise result is q-trim for q>0 and q+trim for q<0. The result never crosses zero.
  - Register out_data and out_ch, set out_valid=1, go to OUT.
- Latency: out_valid rises after the 3rd edge following the accept edge.
- OUT:
  - Hold out_data, out_ch and out_valid stable until out_ready=1 at an edge; then clear out_valid and go to IDLE.
  - No accept happens in OUT. Minimum period is 5 cycles per sample.
- Config writes:
  - Allowed in any state; take effect on the next accept for that channel. The in-flight sample keeps its snapshot.
  - A write to channel c clears sat_flag[c].
  - If a clear and a set for the same channel coincide, the set wins.
- Simultaneous events:
  - cfg_we on the same edge as an accept on the same channel: the accepted sample uses the old values.
  - ch valid dropping before it is granted: nothing is accepted. Requesters must hold valid and data until ready.

Decomposition:
- calib_pkg holds:
  - state enum type (IDLE, MUL, DIV, TRIM, OUT)
  - defaults GAIN_RST and TRIM_RST
  - saturation-limit constants
  - a function for divide-truncate-toward-zero with saturation
- One sub-module, rr_arb2: a 2-requester round-robin arbiter with a last_grant register, enabled by IDLE & en.

Test Plan:
- Reset defaults, ch0_data=1000 -> out_data=973 (250000/256=976, minus 3), out_ch=0, out_valid 3 edges after accept.
- ch1_data=-1000 -> out_data=-973. Separately, ch0_data=2 (500/256=1, |1|<=3) -> out_data=0; ch0_data=-1 -> 0.
- cfg ch0 gain=32767, trim=0, ch0_data=32767 -> out_data=32767 and sat_flag[0]=1. Then a cfg write to ch0 -> sat_flag[0]=0. Same with ch0_data=-32768 -> out_data=-32768.
- Both channels continuously valid, out_ready=1 -> grants alternate 0,1,0,1, one sample every 5 cycles, out_ch alternates to match.
- out_ready held 0 for 10 cycles -> out_data stable, both ready low, no new accept. Release -> IDLE, next grant follows round-robin.
- Accept on ch0, write ch0 gain=128 during MUL, rst asserted in DIV on a second run:
  - First sample uses gain 250.
  - Reset run yields no out_valid.
  - Gain returns to 250, sat_flag=0.

Source files
------------

// File: rtl/calib_pkg.sv
// Shared types, reset defaults and arithmetic helpers for the calibration scheduler.
package calib_pkg;

    localparam int CAL_W         = 16;
    localparam int CAL_FRAC_BITS = 8;
    localparam int DEF_GAIN_RST  = 250;
    localparam int DEF_TRIM_RST  = 3;
    localparam int SAT_MAX       = (2 ** (CAL_W - 1)) - 1;
    localparam int SAT_MIN       = -(2 ** (CAL_W - 1));

    typedef logic [2:0] state_t;

    localparam state_t IDLE = 3'd0;
    localparam state_t MUL  = 3'd1;
    localparam state_t DIV  = 3'd2;
    localparam state_t TRIM = 3'd3;
    localparam state_t OUT  = 3'd4;

    // Negative products get a bias of 2^frac-1 so the shift rounds toward zero, not toward -inf.
    function automatic logic signed [63:0] div_sat(input logic signed [63:0] p,
                                                   input int frac,
                                                   input int w,
                                                   output logic sat);
        logic signed [63:0] bias;
        logic signed [63:0] q;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        bias = (64'sd1 <<< frac) - 64'sd1;
        q    = p[63] ? ((p + bias) >>> frac) : (p >>> frac);
        hi   = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo   = -(64'sd1 <<< (w - 1));
        sat  = 1'b0;
        if (q > hi) begin
            q   = hi;
            sat = 1'b1;
        end else if (q < lo) begin
            q   = lo;
            sat = 1'b1;
        end
        return q;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; a tie goes to the requester not granted last.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic req0,
    input  logic req1,
    output logic grant0,
    output logic grant1
);

    logic last_grant;

    assign grant0 = enable & req0 & (~req1 | last_grant);
    assign grant1 = enable & req1 & (~req0 | ~last_grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (grant0 | grant1) begin
            last_grant <= grant1;
        end
    end

endmodule

// File: rtl/calib_scheduler.sv
// Time-shares one gain/divide/trim/saturate pipeline between two waveform channels
// feeding the DAC interface, one sample in flight at a time.
module calib_scheduler
    import calib_pkg::*;
#(
    parameter int W         = CAL_W,
    parameter int FRAC_BITS = CAL_FRAC_BITS,
    parameter int GAIN_RST  = DEF_GAIN_RST,
    parameter int TRIM_RST  = DEF_TRIM_RST
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         ch0_valid,
    input  logic [W-1:0] ch0_data,
    output logic         ch0_ready,
    input  logic         ch1_valid,
    input  logic [W-1:0] ch1_data,
    output logic         ch1_ready,
    input  logic         cfg_we,
    input  logic         cfg_ch,
    input  logic [W-1:0] cfg_gain,
    input  logic [W-1:0] cfg_trim,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_ch,
    output logic [W-1:0] out_data,
    output logic [1:0]   sat_flag
);

    state_t state;

    logic signed [W-1:0]   gain [2];
    logic        [W-1:0]   trim [2];
    logic signed [W-1:0]   data_r;
    logic signed [W-1:0]   gain_r;
    logic        [W-1:0]   trim_r;
    logic                  ch_r;
    logic signed [2*W-1:0] prod;
    logic signed [W-1:0]   q;
    logic signed [W-1:0]   div_q;
    logic                  div_hit;
    logic signed [W:0]     q_ext;
    logic signed [W:0]     q_abs;
    logic signed [W:0]     trim_ext;
    logic signed [W-1:0]   trimmed;
    logic                  grant0;
    logic                  grant1;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .enable ((state == IDLE) && en),
        .req0   (ch0_valid),
        .req1   (ch1_valid),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign ch0_ready = grant0;
    assign ch1_ready = grant1;

    always_comb begin
        div_hit = 1'b0;
        div_q   = W'(div_sat(64'(prod), FRAC_BITS, W, div_hit));
    end

    // Trim works on magnitude in W+1 bits so |-2^(W-1)| is representable.
    always_comb begin
        q_ext    = {q[W-1], q};
        q_abs    = q_ext[W] ? -q_ext : q_ext;
        trim_ext = {1'b0, trim_r};
        trimmed  = '0;
        if (q_abs > trim_ext) begin
            trimmed = W'(q_ext[W] ? (q_ext + trim_ext) : (q_ext - trim_ext));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_ch    <= 1'b0;
            out_data  <= '0;
            data_r    <= '0;
            gain_r    <= '0;
            trim_r    <= '0;
            ch_r      <= 1'b0;
            prod      <= '0;
            q         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 | grant1) begin
                        data_r <= grant1 ? ch1_data : ch0_data;
                        ch_r   <= grant1;
                        gain_r <= gain[grant1];
                        trim_r <= trim[grant1];
                        state  <= MUL;
                    end
                end
                MUL: begin
                    prod  <= (2*W)'(data_r) * (2*W)'(gain_r);
                    state <= DIV;
                end
                DIV: begin
                    q     <= div_q;
                    state <= TRIM;
                end
                TRIM: begin
                    out_data  <= trimmed;
                    out_ch    <= ch_r;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gain[0] <= W'(GAIN_RST);
            gain[1] <= W'(GAIN_RST);
            trim[0] <= W'(TRIM_RST);
            trim[1] <= W'(TRIM_RST);
        end else if (cfg_we) begin
            gain[cfg_ch] <= cfg_gain;
            trim[cfg_ch] <= cfg_trim;
        end
    end

    // The saturation set is written last so it overrides a same-edge clear from a config write.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= '0;
        end else begin
            if (cfg_we) begin
                sat_flag[cfg_ch] <= 1'b0;
            end
            if ((state == DIV) && div_hit) begin
                sat_flag[ch_r] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_calib_scheduler.sv
// Randomized and directed bench for calib_scheduler against an integer-arithmetic
// model of the calibration rules and round-robin arbitration.
module tb_calib_scheduler;

    localparam int W          = 16;
    localparam int FRAC_BITS  = 8;
    localparam int CLK_PERIOD = 10;

    logic         clk;
    logic         rst;
    logic         en;
    logic         ch0_valid;
    logic [W-1:0] ch0_data;
    logic         ch0_ready;
    logic         ch1_valid;
    logic [W-1:0] ch1_data;
    logic         ch1_ready;
    logic         cfg_we;
    logic         cfg_ch;
    logic [W-1:0] cfg_gain;
    logic [W-1:0] cfg_trim;
    logic         out_valid;
    logic         out_ready;
    logic         out_ch;
    logic [W-1:0] out_data;
    logic [1:0]   sat_flag;

    int     checksTotal  = 0;
    int     checksPassed = 0;
    longint gainM [2];
    longint trimM [2];
    bit     satM  [2];
    int     lastGrant;

    calib_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .ch0_valid (ch0_valid),
        .ch0_data  (ch0_data),
        .ch0_ready (ch0_ready),
        .ch1_valid (ch1_valid),
        .ch1_data  (ch1_data),
        .ch1_ready (ch1_ready),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_gain  (cfg_gain),
        .cfg_trim  (cfg_trim),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .sat_flag  (sat_flag)
    );

    initial clk = 1'b0;
    always #(CLK_PERIOD / 2) clk = ~clk;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checksTotal++;
        if (observed == expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Integer division in SV truncates toward zero, which is exactly the required rounding.
    function automatic longint calModel(input longint d, input longint g, input longint t, output bit sat);
        longint q;
        longint lim;
        q   = (d * g) / (longint'(1) << FRAC_BITS);
        lim = longint'(1) << (W - 1);
        sat = 1'b0;
        if (q > lim - 1) begin
            q   = lim - 1;
            sat = 1'b1;
        end else if (q < -lim) begin
            q   = -lim;
            sat = 1'b1;
        end
        if ((q < 0 ? -q : q) <= t) return 0;
        return (q > 0) ? q - t : q + t;
    endfunction

    task automatic modelReset();
        gainM[0]  = 250;
        gainM[1]  = 250;
        trimM[0]  = 3;
        trimM[1]  = 3;
        satM[0]   = 1'b0;
        satM[1]   = 1'b0;
        lastGrant = 1;
    endtask

    task automatic cfgWrite(input bit c, input longint g, input longint t);
        cfg_we   = 1'b1;
        cfg_ch   = c;
        cfg_gain = g[W-1:0];
        cfg_trim = t[W-1:0];
        @(posedge clk);
        @(negedge clk);
        cfg_we   = 1'b0;
        gainM[c] = g;
        trimM[c] = t;
        satM[c]  = 1'b0;
    endtask

    // Starts and ends at a negedge with the DUT idle; optionally writes config in MUL (1) or DIV (2).
    task automatic applyStimulus(input bit v0, input bit v1,
                                 input logic signed [W-1:0] d0, input logic signed [W-1:0] d1,
                                 input int cfgPhase, input bit cfgC, input longint cfgG, input longint cfgT,
                                 input int stall, output longint acceptTime);
        int          expCh;
        bit          expSat;
        longint      expData;
        int          latency;
        bit          busyReady;
        bit          stallBad;
        logic [W-1:0] held;
        expCh     = (v0 && v1) ? ((lastGrant == 1) ? 0 : 1) : (v0 ? 0 : 1);
        ch0_valid = v0;
        ch1_valid = v1;
        ch0_data  = d0;
        ch1_data  = d1;
        out_ready = (stall == 0);
        #1;
        checkOutput("ch0_ready", ch0_ready, longint'(expCh == 0));
        checkOutput("ch1_ready", ch1_ready, longint'(expCh == 1));
        expData   = calModel((expCh == 0) ? d0 : d1, gainM[expCh], trimM[expCh], expSat);
        lastGrant = expCh;
        @(posedge clk);
        acceptTime = $time;
        latency    = -1;
        busyReady  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ch0_ready || ch1_ready) busyReady = 1'b1;
            if (out_valid) begin
                latency = k;
                break;
            end
            cfg_we   = (k + 1 == cfgPhase);
            cfg_ch   = cfgC;
            cfg_gain = cfgG[W-1:0];
            cfg_trim = cfgT[W-1:0];
        end
        cfg_we = 1'b0;
        if (cfgPhase != 0) begin
            gainM[cfgC] = cfgG;
            trimM[cfgC] = cfgT;
            satM[cfgC]  = 1'b0;
        end
        if (expSat) satM[expCh] = 1'b1;
        checkOutput("latency", latency, 3);
        checkOutput("out_ch", out_ch, expCh);
        checkOutput("out_data", $signed(out_data), expData);
        checkOutput("sat_flag", sat_flag, {satM[1], satM[0]});
        checkOutput("busy_ready", busyReady, 0);
        held     = out_data;
        stallBad = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            @(negedge clk);
            if (!out_valid || out_data != held || ch0_ready || ch1_ready) stallBad = 1'b1;
        end
        if (stall > 0) checkOutput("stall_hold", stallBad, 0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("out_release", out_valid, 0);
        ch0_valid = 1'b0;
        ch1_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        longint t0;
        longint t1;
        bit     bad;
        bit     rv0;
        bit     rv1;
        logic signed [W-1:0] rd0;
        logic signed [W-1:0] rd1;
        longint rg;
        rst       = 1'b1;
        en        = 1'b1;
        ch0_valid = 1'b0;
        ch1_valid = 1'b0;
        ch0_data  = '0;
        ch1_data  = '0;
        cfg_we    = 1'b0;
        cfg_ch    = 1'b0;
        cfg_gain  = '0;
        cfg_trim  = '0;
        out_ready = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_ch", out_ch, 0);
        checkOutput("rst_sat_flag", sat_flag, 0);
        rst = 1'b0;

        applyStimulus(1, 0, 16'sd1000, 16'sd0, 0, 0, 0, 0, 0, t0);
        applyStimulus(0, 1, 16'sd0, -16'sd1000, 0, 0, 0, 0, 0, t0);
        applyStimulus(1, 0, 16'sd2, 16'sd0, 0, 0, 0, 0, 0, t0);
        applyStimulus(1, 0, -16'sd1, 16'sd0, 0, 0, 0, 0, 0, t0);

        cfgWrite(0, 32767, 0);
        applyStimulus(1, 0, 16'sd32767, 16'sd0, 0, 0, 0, 0, 0, t0);
        cfgWrite(0, 32767, 0);
        checkOutput("sat_clear", sat_flag[0], 0);
        applyStimulus(1, 0, -16'sd32768, 16'sd0, 0, 0, 0, 0, 0, t0);
        applyStimulus(1, 0, 16'sd32767, 16'sd0, 2, 0, 32767, 0, 0, t0);
        cfgWrite(0, 250, 3);

        applyStimulus(1, 1, 16'sd100, -16'sd200, 0, 0, 0, 0, 0, t0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 16'sd100, -16'sd200, 0, 0, 0, 0, 0, t1);
            checkOutput("period", t1 - t0, 5 * CLK_PERIOD);
            t0 = t1;
        end

        applyStimulus(1, 1, 16'sd5000, 16'sd7000, 0, 0, 0, 0, 10, t0);
        applyStimulus(1, 1, 16'sd5000, 16'sd7000, 0, 0, 0, 0, 0, t0);

        en        = 1'b0;
        ch0_valid = 1'b1;
        ch1_valid = 1'b1;
        bad       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (ch0_ready || ch1_ready) bad = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (out_valid) bad = 1'b1;
        end
        checkOutput("en_low_idle", bad, 0);
        ch0_valid = 1'b0;
        ch1_valid = 1'b0;
        en        = 1'b1;

        applyStimulus(1, 0, 16'sd1000, 16'sd0, 1, 0, 128, 3, 0, t0);
        cfgWrite(1, 32767, 0);
        applyStimulus(0, 1, 16'sd0, 16'sd32767, 0, 0, 0, 0, 0, t0);

        // Abort a sample in DIV with reset; nothing may come out and config returns to defaults.
        ch0_valid = 1'b1;
        ch0_data  = 16'sd1000;
        #1;
        checkOutput("rst_run_ready", ch0_ready, 1);
        @(posedge clk);
        @(negedge clk);
        ch0_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) bad = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("rst_abort_valid", bad, 0);
        checkOutput("rst_abort_sat", sat_flag, 0);
        applyStimulus(1, 0, 16'sd1000, 16'sd0, 0, 0, 0, 0, 0, t0);
        applyStimulus(0, 1, 16'sd0, -16'sd1000, 0, 0, 0, 0, 0, t0);

        for (int i = 0; i < 40; i++) begin
            rv0 = 1'($urandom_range(0, 1));
            rv1 = 1'($urandom_range(0, 1));
            if (!rv0 && !rv1) rv0 = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                rd0 = W'(int'($urandom_range(0, 2000)) - 1000);
                rd1 = W'(int'($urandom_range(0, 2000)) - 1000);
            end else begin
                rd0 = W'($urandom);
                rd1 = W'($urandom);
            end
            rg = longint'($signed(W'($urandom)));
            applyStimulus(rv0, rv1, rd0, rd1, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                          rg, longint'($urandom_range(0, 400)), int'($urandom_range(0, 3)), t0);
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
